// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame geometry and default line rates.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE         = 16;
    localparam int DEFAULT_CLOCK_FREQ = 100_000_000;
    localparam int DEFAULT_BAUD_RATE  = 9600;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_DATA  = 4'b0100,
        S_STOP  = 4'b1000
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-clock tick every TICK_DIV clocks, held at zero while clear_i is high.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_CLOCK_FREQ / (DEFAULT_BAUD_RATE * OVERSAMPLE)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling with a 2-of-3 mid-bit vote, pending/ack handshake,
// framing-error pulse with break handling and a sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        Rx,
    input  logic        rx_ack,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_pending,
    output logic        frame_err,
    output logic        overrun,
    output logic [15:0] led_debug
);

    localparam int TICK_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int IDX_W    = $clog2(DATA_BITS);

    uart_state_e          state_q;
    logic                 rxMeta_q;
    logic                 rxSync_q;
    logic [3:0]           sampleCnt_q;
    logic [IDX_W-1:0]     bitIdx_q;
    logic                 sample7_q;
    logic                 sample8_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rxData_q;
    logic                 rxValid_q;
    logic                 rxPending_q;
    logic                 frameErr_q;
    logic                 overrun_q;
    logic                 breakWait_q;

    logic tick;
    logic tickClear;
    logic vote_d;
    logic atVote;
    logic atLast;

    // Holding the divider cleared in idle aligns the tick phase to the detected falling edge.
    assign tickClear = (state_q == S_IDLE);

    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_baud_tick (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (tickClear),
        .tick_o  (tick)
    );

    assign vote_d = majority3(sample7_q, sample8_q, rxSync_q);
    assign atVote = tick && (sampleCnt_q == 4'd9);
    assign atLast = tick && (sampleCnt_q == 4'd15);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= Rx;
            rxSync_q <= rxMeta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sampleCnt_q <= '0;
            bitIdx_q    <= '0;
            sample7_q   <= 1'b1;
            sample8_q   <= 1'b1;
            shift_q     <= '0;
            rxData_q    <= '0;
            rxValid_q   <= 1'b0;
            rxPending_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
            breakWait_q <= 1'b0;
        end else begin
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            if (rx_ack) begin
                rxPending_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
            if (tick) begin
                sampleCnt_q <= sampleCnt_q + 4'd1;
                if (sampleCnt_q == 4'd7) sample7_q <= rxSync_q;
                if (sampleCnt_q == 4'd8) sample8_q <= rxSync_q;
            end

            case (state_q)
                S_IDLE: begin
                    breakWait_q <= 1'b0;
                    if (!rxSync_q) begin
                        state_q     <= S_START;
                        sampleCnt_q <= '0;
                        bitIdx_q    <= '0;
                    end
                end
                S_START: begin
                    if (atVote && vote_d) begin
                        state_q <= S_IDLE;
                    end else if (atLast) begin
                        state_q  <= S_DATA;
                        bitIdx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (atVote) begin
                        shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
                    end
                    if (atLast) begin
                        if (bitIdx_q == IDX_W'(DATA_BITS - 1)) begin
                            state_q <= S_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    // A bad stop bit parks here until the line returns high so a break is one error.
                    if (breakWait_q) begin
                        if (rxSync_q) begin
                            state_q     <= S_IDLE;
                            breakWait_q <= 1'b0;
                        end
                    end else if (atVote) begin
                        if (vote_d) begin
                            rxData_q    <= shift_q;
                            rxValid_q   <= 1'b1;
                            rxPending_q <= 1'b1;
                            if (rxPending_q && !rx_ack) overrun_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            frameErr_q  <= 1'b1;
                            breakWait_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data    = rxData_q;
    assign rx_valid   = rxValid_q;
    assign rx_pending = rxPending_q;
    assign frame_err  = frameErr_q;
    assign overrun    = overrun_q;
    assign led_debug  = {rxData_q, 1'b0, overrun_q, rxPending_q, rxSync_q, state_q};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scaled clock so one bit is 128 clocks; received bytes are
// checked against a queue of expected bytes filled as frames are driven.
module tb_uart_rx;

    localparam int BAUD      = 9600;
    localparam int CLK_FREQ  = BAUD * 16 * 8;
    localparam int BIT_CLKS  = 128;
    localparam int SLOW_CLKS = 124;

    logic        clk;
    logic        reset_n;
    logic        Rx;
    logic        rx_ack;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pending;
    logic        frame_err;
    logic        overrun;
    logic [15:0] led_debug;

    logic [7:0]  expQ[$];
    logic [7:0]  expByte;
    int          compared      = 0;
    int          mismatched    = 0;
    int          validCount    = 0;
    int          frameErrCount = 0;
    int          validBase;
    int          errBase;

    uart_rx #(.CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Rx         (Rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_pending (rx_pending),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .led_debug  (led_debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame, one value per clock; spikeAt forces a single low clock, stopAfter truncates.
    task automatic applyStimulus(input logic [7:0] data, input int clksPerBit, input logic stopVal,
                                 input int spikeAt, input int stopAfter, input bit expectGood);
        int bitPos;
        logic val;
        if (expectGood) expQ.push_back(data);
        for (int c = 0; c < 10 * clksPerBit && c < stopAfter; c++) begin
            bitPos = c / clksPerBit;
            if (bitPos == 0)      val = 1'b0;
            else if (bitPos < 9)  val = data[bitPos-1];
            else                  val = stopVal;
            if (c == spikeAt) val = 1'b0;
            Rx = val;
            @(negedge clk);
        end
        Rx = 1'b1;
    endtask

    task automatic ackPulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                validCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'd1, 32'd0);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("rxData", {24'd0, rx_data}, {24'd0, expByte});
                end
            end
            if (frame_err) frameErrCount++;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        Rx      = 1'b1;
        rx_ack  = 1'b0;
        reset_n = 1'b0;
        #50;
        checkOutput("resetData", {24'd0, rx_data}, 32'd0);
        checkOutput("resetFlags", {27'd0, rx_valid, rx_pending, frame_err, overrun, 1'b0}, 32'd0);
        checkOutput("resetLeds", {16'd0, led_debug}, 32'h0011);
        #50;
        reset_n = 1'b1;
        waitClocks(2 * BIT_CLKS);
        checkOutput("idleValid", validCount, 0);
        checkOutput("idleFrameErr", frameErrCount, 0);
        checkOutput("idleLeds", {16'd0, led_debug}, 32'h0011);

        $display("[TB] single byte 0xA5");
        validBase = validCount;
        applyStimulus(8'hA5, BIT_CLKS, 1'b1, -1, 100000, 1'b1);
        waitClocks(32);
        checkOutput("singleValidCount", validCount - validBase, 1);
        checkOutput("singleData", {24'd0, rx_data}, 32'hA5);
        checkOutput("singlePending", {31'd0, rx_pending}, 32'd1);
        checkOutput("singleFrameErr", frameErrCount, 0);
        ackPulse();
        checkOutput("singleAckPending", {31'd0, rx_pending}, 32'd0);

        $display("[TB] back-to-back 0x3C 0xC3");
        validBase = validCount;
        applyStimulus(8'h3C, BIT_CLKS, 1'b1, -1, 100000, 1'b1);
        applyStimulus(8'hC3, BIT_CLKS, 1'b1, -1, 100000, 1'b1);
        waitClocks(32);
        checkOutput("b2bValidCount", validCount - validBase, 2);
        checkOutput("b2bData", {24'd0, rx_data}, 32'hC3);
        checkOutput("b2bOverrun", {31'd0, overrun}, 32'd1);
        ackPulse();
        checkOutput("b2bAckOverrun", {31'd0, overrun}, 32'd0);
        checkOutput("b2bAckPending", {31'd0, rx_pending}, 32'd0);

        $display("[TB] glitch rejection");
        validBase = validCount;
        errBase   = frameErrCount;
        Rx = 1'b0;
        waitClocks(37);
        Rx = 1'b1;
        waitClocks(2 * BIT_CLKS);
        checkOutput("glitchState", {28'd0, led_debug[3:0]}, 32'h1);
        checkOutput("glitchValid", validCount - validBase, 0);
        checkOutput("glitchFrameErr", frameErrCount - errBase, 0);
        applyStimulus(8'h55, BIT_CLKS, 1'b1, -1, 100000, 1'b1);
        waitClocks(32);
        checkOutput("glitchNextData", {24'd0, rx_data}, 32'h55);
        ackPulse();

        $display("[TB] framing error and break");
        validBase = validCount;
        errBase   = frameErrCount;
        applyStimulus(8'h81, BIT_CLKS, 1'b0, -1, 100000, 1'b0);
        Rx = 1'b0;
        waitClocks(3 * BIT_CLKS);
        checkOutput("breakFrameErr", frameErrCount - errBase, 1);
        checkOutput("breakData", {24'd0, rx_data}, 32'h55);
        checkOutput("breakState", {28'd0, led_debug[3:0]}, 32'h8);
        checkOutput("breakPending", {31'd0, rx_pending}, 32'd0);
        Rx = 1'b1;
        waitClocks(BIT_CLKS);
        checkOutput("breakIdle", {28'd0, led_debug[3:0]}, 32'h1);
        applyStimulus(8'h7E, BIT_CLKS, 1'b1, -1, 100000, 1'b1);
        waitClocks(32);
        checkOutput("afterBreakData", {24'd0, rx_data}, 32'h7E);
        checkOutput("afterBreakValid", validCount - validBase, 1);
        checkOutput("afterBreakFrameErr", frameErrCount - errBase, 1);
        ackPulse();

        // Slow sender (-3%) with a one-clock low spike on sample 8 of data bit 1, the first 1 bit of 0x96.
        $display("[TB] rate tolerance and noise");
        applyStimulus(8'h96, SLOW_CLKS, 1'b1, 41 * 8, 100000, 1'b1);
        waitClocks(32);
        checkOutput("slowData", {24'd0, rx_data}, 32'h96);
        ackPulse();

        $display("[TB] reset mid-frame");
        validBase = validCount;
        errBase   = frameErrCount;
        applyStimulus(8'h0F, BIT_CLKS, 1'b1, -1, 5 * BIT_CLKS + BIT_CLKS / 2, 1'b0);
        reset_n = 1'b0;
        waitClocks(2);
        checkOutput("midResetData", {24'd0, rx_data}, 32'd0);
        checkOutput("midResetFlags", {27'd0, rx_valid, rx_pending, frame_err, overrun, 1'b0}, 32'd0);
        checkOutput("midResetLeds", {16'd0, led_debug}, 32'h0011);
        reset_n = 1'b1;
        waitClocks(12 * BIT_CLKS);
        checkOutput("midResetValid", validCount - validBase, 0);
        checkOutput("midResetFrameErr", frameErrCount - errBase, 0);
        checkOutput("midResetIdleLeds", {16'd0, led_debug}, 32'h0011);
        checkOutput("queueDrained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
